// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator: slews G1/G2 to a requested code phase,
// then emits one chip per chip_en with chip index and epoch pulse.
module ca_code_gen #(
    parameter int CODE_LEN = 1023,
    parameter int PHASE_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [5:0]         sat,
    input  logic [PHASE_W-1:0] phase,
    input  logic               chip_en,
    output logic               busy,
    output logic               chip_valid,
    output logic               chip,
    output logic [PHASE_W-1:0] chip_idx,
    output logic               epoch,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLEW = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_IDX = PHASE_W'(CODE_LEN - 1);
    localparam logic [PHASE_W-1:0] ONE      = PHASE_W'(1);
    localparam logic [10:1]        ALL_ONES = 10'h3FF;

    state_t             state_r, state_s;
    logic [10:1]        g1_r, g1_s;
    logic [10:1]        g2_r, g2_s;
    logic [10:1]        mask_r, mask_s;
    logic [PHASE_W-1:0] cnt_r, cnt_s;
    logic [PHASE_W-1:0] idx_r, idx_s;
    logic               epoch_r, epoch_s;
    logic               err_r, err_s;
    logic               load_ok_s;

    function automatic logic [10:1] g1_step(input logic [10:1] g);
        return {g[9:1], g[3] ^ g[10]};
    endfunction

    function automatic logic [10:1] g2_step(input logic [10:1] g);
        return {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
    endfunction

    function automatic logic [10:1] stage_bit(input logic [3:0] k);
        return 10'd1 << (k - 4'd1);
    endfunction

    // The two G2 phase-select taps stored as a mask, so the chip is a parity of G2 & mask.
    function automatic logic [10:1] tap_mask(input logic [5:0] prn);
        logic [3:0] t1;
        logic [3:0] t2;
        t1 = 4'd0;
        t2 = 4'd0;
        case (prn)
            6'd1:  begin t1 = 4'd2; t2 = 4'd6;  end
            6'd2:  begin t1 = 4'd3; t2 = 4'd7;  end
            6'd3:  begin t1 = 4'd4; t2 = 4'd8;  end
            6'd4:  begin t1 = 4'd5; t2 = 4'd9;  end
            6'd5:  begin t1 = 4'd1; t2 = 4'd9;  end
            6'd6:  begin t1 = 4'd2; t2 = 4'd10; end
            6'd7:  begin t1 = 4'd1; t2 = 4'd8;  end
            6'd8:  begin t1 = 4'd2; t2 = 4'd9;  end
            6'd9:  begin t1 = 4'd3; t2 = 4'd10; end
            6'd10: begin t1 = 4'd2; t2 = 4'd3;  end
            6'd11: begin t1 = 4'd3; t2 = 4'd4;  end
            6'd12: begin t1 = 4'd5; t2 = 4'd6;  end
            6'd13: begin t1 = 4'd6; t2 = 4'd7;  end
            6'd14: begin t1 = 4'd7; t2 = 4'd8;  end
            6'd15: begin t1 = 4'd8; t2 = 4'd9;  end
            6'd16: begin t1 = 4'd9; t2 = 4'd10; end
            6'd17: begin t1 = 4'd1; t2 = 4'd4;  end
            6'd18: begin t1 = 4'd2; t2 = 4'd5;  end
            6'd19: begin t1 = 4'd3; t2 = 4'd6;  end
            6'd20: begin t1 = 4'd4; t2 = 4'd7;  end
            6'd21: begin t1 = 4'd5; t2 = 4'd8;  end
            6'd22: begin t1 = 4'd6; t2 = 4'd9;  end
            6'd23: begin t1 = 4'd1; t2 = 4'd3;  end
            6'd24: begin t1 = 4'd4; t2 = 4'd6;  end
            6'd25: begin t1 = 4'd5; t2 = 4'd7;  end
            6'd26: begin t1 = 4'd6; t2 = 4'd8;  end
            6'd27: begin t1 = 4'd7; t2 = 4'd9;  end
            6'd28: begin t1 = 4'd8; t2 = 4'd10; end
            6'd29: begin t1 = 4'd1; t2 = 4'd6;  end
            6'd30: begin t1 = 4'd2; t2 = 4'd7;  end
            6'd31: begin t1 = 4'd3; t2 = 4'd8;  end
            6'd32: begin t1 = 4'd4; t2 = 4'd9;  end
            default: begin t1 = 4'd0; t2 = 4'd0; end
        endcase
        if (t1 == 4'd0) begin
            return 10'h000;
        end else begin
            return stage_bit(t1) | stage_bit(t2);
        end
    endfunction

    function automatic logic gold_chip(input logic [10:1] g1, input logic [10:1] g2,
                                       input logic [10:1] mask);
        return g1[10] ^ (^(g2 & mask));
    endfunction

    assign load_ok_s = (sat >= 6'd1) && (sat <= 6'd32) && (phase <= LAST_IDX);

    // Next-state: load has priority over slewing and chip_en in every state.
    always_comb begin
        state_s = state_r;
        g1_s    = g1_r;
        g2_s    = g2_r;
        mask_s  = mask_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        epoch_s = 1'b0;
        err_s   = 1'b0;
        if (load) begin
            g1_s  = ALL_ONES;
            g2_s  = ALL_ONES;
            idx_s = '0;
            if (load_ok_s) begin
                state_s = SLEW;
                cnt_s   = phase;
                mask_s  = tap_mask(sat);
            end else begin
                state_s = IDLE;
                cnt_s   = '0;
                err_s   = 1'b1;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                SLEW: begin
                    if (cnt_r != '0) begin
                        g1_s  = g1_step(g1_r);
                        g2_s  = g2_step(g2_r);
                        cnt_s = cnt_r - ONE;
                        idx_s = idx_r + ONE;
                    end else begin
                        state_s = RUN;
                    end
                end
                RUN: begin
                    if (chip_en && (idx_r == LAST_IDX)) begin
                        // Explicit reload keeps the code aligned even if a step were ever miscounted.
                        g1_s    = ALL_ONES;
                        g2_s    = ALL_ONES;
                        idx_s   = '0;
                        epoch_s = 1'b1;
                    end else if (chip_en) begin
                        g1_s  = g1_step(g1_r);
                        g2_s  = g2_step(g2_r);
                        idx_s = idx_r + ONE;
                    end else begin
                        idx_s = idx_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, LFSR, tap and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            g1_r    <= ALL_ONES;
            g2_r    <= ALL_ONES;
            mask_r  <= 10'h000;
            cnt_r   <= '0;
            idx_r   <= '0;
            epoch_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            g1_r    <= g1_s;
            g2_r    <= g2_s;
            mask_r  <= mask_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            epoch_r <= epoch_s;
            err_r   <= err_s;
        end
    end

    assign busy       = (state_r == SLEW);
    assign chip_valid = (state_r == RUN);
    assign chip_idx   = idx_r;
    assign epoch      = epoch_r;
    assign err        = err_r;
    assign chip       = chip_valid & gold_chip(g1_r, g2_r, mask_r);

endmodule

// File: tb/tb_ca_code_gen.sv
// Randomized scoreboard bench for ca_code_gen; the expected chip stream comes
// from the G1/G2 m-sequence recurrences and the per-PRN G2 code delays.
module tb_ca_code_gen;

    logic       clk;
    logic       rst;
    logic       load;
    logic [5:0] sat;
    logic [9:0] phase;
    logic       chip_en;
    logic       busy;
    logic       chip_valid;
    logic       chip;
    logic [9:0] chip_idx;
    logic       epoch;
    logic       err;

    ca_code_gen #(.CODE_LEN(1023), .PHASE_W(10)) dut (
        .clk(clk), .rst(rst), .load(load), .sat(sat), .phase(phase),
        .chip_en(chip_en), .busy(busy), .chip_valid(chip_valid), .chip(chip),
        .chip_idx(chip_idx), .epoch(epoch), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic       err;
        logic       epoch;
        logic       idx_chk;
        logic [9:0] idx;
        logic       chip;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    bit g1s [0:1022];
    bit g2s [0:1022];
    int dly [0:32] = '{0, 5, 6, 7, 8, 17, 18, 139, 140, 141, 251, 252, 254, 255, 256,
                       257, 258, 469, 470, 471, 472, 473, 474, 509, 512, 513, 514,
                       515, 516, 859, 860, 861, 862};

    // Reference model state: 0 idle, 1 slewing, 2 running.
    int m_mode = 0;
    int m_busy_left = 0;
    int m_target = 0;
    int m_idx = 0;
    int m_prn = 1;

    function automatic bit ref_chip(input int prn, input int k);
        return g1s[k] ^ g2s[(k + 1023 - dly[prn]) % 1023];
    endfunction

    task automatic build_ref();
        for (int n = 0; n < 10; n++) begin
            g1s[n] = 1'b1;
            g2s[n] = 1'b1;
        end
        for (int n = 0; n < 1013; n++) begin
            g1s[n+10] = g1s[n+7] ^ g1s[n];
            g2s[n+10] = g2s[n+8] ^ g2s[n+7] ^ g2s[n+4] ^ g2s[n+2] ^ g2s[n+1] ^ g2s[n];
        end
    endtask

    task automatic check_model_head(input int prn, input logic [9:0] want);
        logic [9:0] v;
        v = 10'd0;
        for (int k = 0; k < 10; k++) v = {v[8:0], ref_chip(prn, k)};
        n_total++;
        if (v == want) n_pass++;
        else $display("FAIL model_head_prn%0d: got %o want %o", prn, v, want);
    endtask

    // One cycle: drive inputs just after the falling edge, advance the model, queue what the next cycle shows.
    task automatic cyc(input logic l, input logic [5:0] s, input logic [9:0] p,
                       input logic ce, input logic r);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; load = l; sat = s; phase = p; chip_en = ce;
        e = '0;
        if (r) begin
            m_mode = 0;
            m_idx  = 0;
            e.idx_chk = 1'b1;
        end else if (l) begin
            if (s >= 6'd1 && s <= 6'd32 && p <= 10'd1022) begin
                m_mode = 1;
                m_busy_left = int'(p) + 1;
                m_target = int'(p);
                m_prn = int'(s);
            end else begin
                m_mode = 0;
                e.err = 1'b1;
            end
        end else if (m_mode == 1) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_mode = 2;
                m_idx = m_target;
            end
        end else if (m_mode == 2 && ce) begin
            e.epoch = (m_idx == 1022);
            m_idx = (m_idx + 1) % 1023;
        end
        e.busy  = (m_mode == 1);
        e.valid = (m_mode == 2);
        if (e.valid) begin
            e.idx_chk = 1'b1;
            e.idx  = 10'(m_idx);
            e.chip = ref_chip(m_prn, m_idx);
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input int pct);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 10'd0, ($urandom_range(0, 99) < pct), 1'b0);
    endtask

    task automatic do_load(input int s, input int p, input logic ce);
        cyc(1'b1, 6'(s), 10'(p), ce, 1'b0);
    endtask

    // Monitor: every queued cycle is compared on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_total++;
            if (busy === e.busy && chip_valid === e.valid && err === e.err &&
                epoch === e.epoch && chip === e.chip &&
                (!e.idx_chk || chip_idx === e.idx)) begin
                n_pass++;
            end else begin
                $display("FAIL cycle_out t=%0t: busy=%b valid=%b err=%b epoch=%b idx=%0d chip=%b, expected busy=%b valid=%b err=%b epoch=%b idx=%0d(chk %b) chip=%b",
                         $time, busy, chip_valid, err, epoch, chip_idx, chip,
                         e.busy, e.valid, e.err, e.epoch, e.idx, e.idx_chk, e.chip);
            end
        end
    end

    initial begin
        int s;
        int p;
        rst = 1'b1; load = 1'b0; sat = 6'd0; phase = 10'd0; chip_en = 1'b0;
        build_ref();
        check_model_head(1, 10'o1440);
        check_model_head(2, 10'o1620);

        repeat (3) cyc(1'b0, 6'd0, 10'd0, 1'b0, 1'b1);
        run(2, 100);

        // Phase-0 starts on PRN 1 and 2.
        do_load(1, 0, 1'b1);
        run(14, 100);
        do_load(2, 0, 1'b1);
        run(14, 100);

        // Slew to 123 and run past a full period.
        do_load(1, 123, 1'b1);
        run(1200, 100);

        // Near-wrap start with chip_en gaps, two epochs.
        do_load(1, 1020, 1'b1);
        run(2200, 70);

        // Rejected loads, including one while running.
        do_load(0, 5, 1'b0);
        run(3, 100);
        do_load(33, 5, 1'b0);
        run(3, 100);
        do_load(3, 1023, 1'b1);
        run(3, 100);
        do_load(4, 2, 1'b1);
        run(6, 100);
        do_load(63, 0, 1'b1);
        run(3, 100);

        // Reset in the middle of a slew, then reloads mid-RUN.
        do_load(9, 500, 1'b1);
        run(200, 100);
        cyc(1'b0, 6'd0, 10'd0, 1'b1, 1'b1);
        cyc(1'b0, 6'd0, 10'd0, 1'b1, 1'b1);
        run(3, 100);
        do_load(5, 1021, 1'b1);
        run(1030, 100);
        do_load(7, 1022, 1'b1);
        run(1025, 100);
        do_load(12, 3, 1'b1);
        run(20, 100);

        // Randomized traffic across all PRNs.
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 5) == 0) s = $urandom_range(0, 63);
            else s = $urandom_range(1, 32);
            case ($urandom_range(0, 3))
                0: p = $urandom_range(0, 1023);
                1: p = $urandom_range(1010, 1022);
                2: p = $urandom_range(0, 8);
                default: p = $urandom_range(0, 1022);
            endcase
            do_load(s, p, 1'b1);
            run($urandom_range(20, 1200), $urandom_range(30, 100));
            if ($urandom_range(0, 7) == 0) cyc(1'b0, 6'd0, 10'd0, 1'b1, 1'b1);
        end
        run(4, 100);

        @(negedge clk);
        @(negedge clk);
        #2;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ca_code_gen.md
Name: ca_code_gen

Overview:
- Streaming GPS L1 C/A Gold-code generator: the transmit/replica end of the C/A correlation path.
- Takes a satellite PRN (1..32) and a starting code phase (0..1022), slews its G1/G2 LFSRs to that phase, then emits one chip per chip-enable.
- Provides chip index and epoch pulse for the correlator and integrate-and-dump logic downstream.

Parameters:
CODE_LEN, 1023, chips per code period; fixed for L1 C/A, used for index wrap.
PHASE_W, 10, width of phase and chip-index fields.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load  in  1  one-cycle request: latch sat and phase, restart generator
sat  in  6  PRN number, valid 1..32
phase  in  PHASE_W  starting chip index, valid 0..1022
chip_en  in  1  advance one chip (honoured only in RUN)
busy  out  1  high in SLEW
chip_valid  out  1  high in RUN; chip and chip_idx are meaningful
chip  out  1  current chip = G1[10] ^ G2[t1] ^ G2[t2]
chip_idx  out  PHASE_W  index of current chip, 0..1022
epoch  out  1  one-cycle pulse on the cycle chip_idx wraps 1022->0
err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset, asynchronous: state IDLE; G1=G2=10'h3FF; counter=0; chip_idx=0; busy, chip_valid, epoch, err = 0; chip = 0 (forced 0 outside RUN).
- Registers G1[10:1], G2[10:1]. One step: G1 <= {G1[9:1], G1[3]^G1[10]}; G2 <= {G2[9:1], G2[2]^G2[3]^G2[6]^G2[8]^G2[9]^G2[10]}.
- Chip 0 corresponds to G1=G2=all-ones.
- Tap table (t1,t2), PRN 1..32: (2,6)(3,7)(4,8)(5,9)(1,9)(2,10)(1,8)(2,9)(3,10)(2,3)(3,4)(5,6)(6,7)(7,8)(8,9)(9,10)(1,4)(2,5)(3,6)(4,7)(5,8)(6,9)(1,3)(4,6)(5,7)(6,8)(7,9)(8,10)(1,6)(2,7)(3,8)(4,9).
- Taps are registered at load; changes on sat after load are ignored.
- States:
  - IDLE: outputs invalid; chip_en ignored.
  - SLEW: each cycle with counter != 0, step both LFSRs, counter--, chip_idx++. When counter == 0, go to RUN next cycle with no step.
  - RUN: chip_valid=1. On chip_en, step both LFSRs and chip_idx++.
- Load, accepted in any state (overrides chip_en and slew in the same cycle):
  - If sat in 1..32 and phase <= 1022: G1=G2=all-ones, chip_idx=0, counter=phase, latch taps, go to SLEW.
  - Otherwise: err=1 for one cycle, go to IDLE, LFSRs reset to all-ones.
- Latency: load at cycle N with phase P gives busy high for cycles N+1..N+P+1 and chip_valid high from cycle N+P+2, with chip_idx=P. P=0 gives one SLEW cycle.
- Wrap: on chip_en in RUN with chip_idx=1022, chip_idx <= 0 and G1,G2 reload to all-ones explicitly. epoch=1 on the following cycle, coincident with chip_idx=0. No epoch is generated when SLEW/load lands on index 0.
- chip is combinational from registered LFSRs and taps, gated by chip_valid.
- Reset mid-SLEW or mid-RUN: immediate return to the reset state; no epoch or err pulse.

Test Plan:
- Reset release, load sat=1 phase=0, chip_en held 1 -> chip_valid at N+2, first 10 chips 1,1,0,0,1,0,0,0,0,0 (octal 1440); busy high for exactly 1 cycle.
- Load sat=2 phase=0 -> first 10 chips 1,1,1,0,0,1,0,0,0,0 (octal 1620).
- Free-run sat=1 for 1023 chips into reference array; reload sat=1 phase=123 -> busy 124 cycles, chip_idx=123 at valid, next 1023 chips equal array[(123+k) mod 1023].
- Sat=1 phase=1020, chip_en=1 -> epoch pulses exactly once after 3 chips, with chip_idx=0 and chip=1; next pulse 1023 chips later; chip_en=0 gaps hold chip and chip_idx.
- Load sat=0, then sat=33, then phase=1023 -> err pulse each time, state IDLE, chip_valid=0, chip=0.
- Load phase=500, assert rst at slew cycle 200 -> all outputs at reset values; new load mid-RUN restarts SLEW with no epoch.
